// File: rtl/task_frame_scheduler.sv
// rtl/task_frame_scheduler.sv - round-robin frame arbiter muxing NUM_CH task channels into one core
// A grant is held for a whole frame and released on core completion or on an idle timeout.
module task_frame_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int FRAME_WORDS    = 243,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH-1:0]            i_enb,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic                         i_output_last,
  output logic [NUM_CH-1:0]            o_grant,
  output logic                         o_start,
  output logic                         o_enb,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(NUM_CH)-1:0]    o_ch_id,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [TC_W-1:0]     tcnt_q, tcnt_d;

  logic                pick_vld;
  logic [CH_W-1:0]     pick_ch;
  logic [CH_W:0]       arb_idx;
  logic                g_enb;
  logic [DATA_WIDTH-1:0] g_data;

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    arb_idx  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      arb_idx = {1'b0, last_q} + (CH_W + 1)'(i);
      if (arb_idx >= NUM_CH_W) arb_idx = arb_idx - NUM_CH_W;
      if (i_req[arb_idx[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_ch  = arb_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    g_enb  = 1'b0;
    g_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == ch_q) begin
        g_enb  = i_enb[k];
        g_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    o_start   = 1'b0;
    o_enb     = 1'b0;
    o_data    = '0;
    o_timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          ch_d    = pick_ch;
          grant_d = NUM_CH'(1) << pick_ch;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        o_start = 1'b1;
        wcnt_d  = '0;
        tcnt_d  = '0;
        state_d = S_XFER;
      end
      S_XFER, S_WAIT_DONE: begin
        if (state_q == S_XFER) begin
          o_enb  = g_enb;
          o_data = g_data;
        end
        if (state_q == S_XFER && g_enb) begin
          wcnt_d = wcnt_q + WC_W'(1);
          tcnt_d = '0;
          if (wcnt_q == WC_W'(FRAME_WORDS - 1)) state_d = S_WAIT_DONE;
        end else if (i_output_last) begin
          tcnt_d = '0;
          if (state_q == S_WAIT_DONE) begin
            last_d  = ch_q;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end else if (tcnt_q == TC_W'(TIMEOUT_CYCLES - 1)) begin
          o_timeout = 1'b1;
          tcnt_d    = '0;
          last_d    = ch_q;
          grant_d   = '0;
          state_d   = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset suppresses pulses that would otherwise leak out of an aborted frame.
    if (i_rst) begin
      o_start   = 1'b0;
      o_enb     = 1'b0;
      o_data    = '0;
      o_timeout = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      grant_q <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign o_grant = grant_q;
  assign o_ch_id = ch_q;
  assign o_busy  = (state_q != S_IDLE) && !i_rst;

endmodule

// File: tb/tb_task_frame_scheduler.sv
// tb/tb_task_frame_scheduler.sv - directed vector bench for task_frame_scheduler
module tb_task_frame_scheduler;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int FW     = 243;
  localparam int TO     = 1024;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [NUM_CH-1:0]    i_req;
  logic [NUM_CH-1:0]    i_enb;
  logic [NUM_CH*DW-1:0] i_data;
  logic                 i_output_last;
  logic [NUM_CH-1:0]    o_grant;
  logic                 o_start;
  logic                 o_enb;
  logic [DW-1:0]        o_data;
  logic [1:0]           o_ch_id;
  logic                 o_busy;
  logic                 o_timeout;

  task_frame_scheduler #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FRAME_WORDS(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_enb(i_enb), .i_data(i_data),
    .i_output_last(i_output_last), .o_grant(o_grant), .o_start(o_start),
    .o_enb(o_enb), .o_data(o_data), .o_ch_id(o_ch_id), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [NUM_CH-1:0] req;
    bit                iso;
    int                exp_ch;
  } frame_vec_t;

  frame_vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_grant(input int exp_ch);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk); #1;
      if (o_grant !== '0) break;
    end
    check("grant", 64'(o_grant), 64'(1) << exp_ch);
    check("ch_id", 64'(o_ch_id), 64'(exp_ch));
    check("start_pulse", {63'b0, o_start}, 64'd1);
    check("busy_grant", {63'b0, o_busy}, 64'd1);
  endtask

  task automatic send_words(input int ch, input int n, input bit iso);
    int bad = 0;
    logic [NUM_CH*DW-1:0] d;
    for (int w = 0; w < n; w++) begin
      if (iso && (w % 3 == 0)) begin
        @(negedge i_clk);
        i_enb  = 4'b0001;
        i_data = $urandom;
        #1;
        if (o_enb !== 1'b0) bad++;
      end
      @(negedge i_clk);
      i_enb = 4'b0001 << ch;
      if (iso) i_enb[0] = (w % 2 == 1);
      d = $urandom;
      i_data = d;
      #1;
      if (o_enb !== 1'b1 || o_data !== DW'(d >> (ch * DW))) bad++;
    end
    check("xfer_words", 64'(bad), 64'd0);
  endtask

  task automatic finish_frame(input int ch);
    @(negedge i_clk);
    i_enb  = 4'b0001 << ch;
    i_data = $urandom;
    #1;
    check("drop_after_frame", {55'b0, o_enb, o_data}, 64'd0);
    check("busy_wait_done", {63'b0, o_busy}, 64'd1);
    i_enb = '0;
    i_output_last = 1'b1;
    @(negedge i_clk);
    i_output_last = 1'b0;
    #1;
    check("idle_after_last", {59'b0, o_busy, o_grant}, 64'd0);
  endtask

  initial begin
    int pulses;
    int first;

    vecs[0] = '{4'b1111, 1'b0, 0};
    vecs[1] = '{4'b1111, 1'b0, 1};
    vecs[2] = '{4'b1111, 1'b1, 2};
    vecs[3] = '{4'b1111, 1'b0, 3};
    vecs[4] = '{4'b1111, 1'b0, 0};
    vecs[5] = '{4'b0001, 1'b0, 0};
    vecs[6] = '{4'b1010, 1'b0, 1};
    vecs[7] = '{4'b1000, 1'b0, 3};
    vecs[8] = '{4'b0101, 1'b0, 0};
    vecs[9] = '{4'b0100, 1'b1, 2};

    i_rst = 1'b1; i_req = '0; i_enb = '0; i_data = '0; i_output_last = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check("reset_outputs", {o_grant, o_start, o_enb, o_data, o_ch_id, o_busy, o_timeout}, 64'd0);
    i_rst = 1'b0;
    i_enb = 4'b1111; i_data = '1; i_output_last = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    check("idle_no_req", {o_grant, o_start, o_enb, o_data, o_ch_id, o_busy, o_timeout}, 64'd0);
    i_enb = '0; i_data = '0; i_output_last = 1'b0;

    foreach (vecs[v]) begin
      i_req = vecs[v].req;
      do_grant(vecs[v].exp_ch);
      send_words(vecs[v].exp_ch, FW, vecs[v].iso);
      finish_frame(vecs[v].exp_ch);
    end

    // i_output_last mid-frame must not end the transfer
    i_req = 4'b0010;
    do_grant(1);
    send_words(1, 100, 1'b0);
    @(negedge i_clk);
    i_enb = '0; i_output_last = 1'b1;
    @(negedge i_clk);
    i_output_last = 1'b0;
    #1;
    check("early_last_busy", {63'b0, o_busy}, 64'd1);
    check("early_last_grant", 64'(o_grant), 64'b0010);
    send_words(1, FW - 100, 1'b0);
    finish_frame(1);

    // Stall after 10 words; grant must be abandoned on the 1024th idle cycle
    i_req = 4'b0010;
    do_grant(1);
    send_words(1, 10, 1'b0);
    i_req = 4'b0110;
    pulses = 0;
    first = 0;
    for (int c = 1; c <= TO + 2; c++) begin
      @(negedge i_clk);
      i_enb = '0;
      #1;
      if (o_timeout === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == TO + 1) check("idle_after_timeout", {59'b0, o_busy, o_grant}, 64'd0);
      if (c == TO + 2) begin
        check("grant_after_timeout", 64'(o_grant), 64'b0100);
        check("start_after_timeout", {63'b0, o_start}, 64'd1);
      end
    end
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_cycle", 64'(first), 64'(TO));
    send_words(2, FW, 1'b0);
    finish_frame(2);

    // Reset at word 50 of a ch3 frame
    i_req = 4'b1000;
    do_grant(3);
    send_words(3, 50, 1'b0);
    @(negedge i_clk);
    i_enb = 4'b1000;
    i_rst = 1'b1;
    #1;
    check("rst_cycle_enb", {62'b0, o_enb, o_timeout}, 64'd0);
    @(negedge i_clk);
    #1;
    check("rst_abort_outputs", {o_grant, o_start, o_enb, o_data, o_ch_id, o_busy, o_timeout}, 64'd0);
    i_rst = 1'b0;
    i_enb = '0;
    i_req = 4'b1111;
    do_grant(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/task_frame_scheduler.md
TASK_FRAME_SCHEDULER -- requirements
Module: task_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of task input channels sharing the core (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each channel's data word.
REQ-003 SHALL have parameter FRAME_WORDS, default 243, number of words per frame.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, number of idle cycles before a grant is abandoned.
REQ-005 SHALL have port i_clk  in  1  clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_req  in  NUM_CH  bit k high: channel k holds a complete buffered frame.
REQ-008 SHALL have port i_enb  in  NUM_CH  bit k high: channel k data word valid this cycle.
REQ-009 SHALL have port i_data  in  NUM_CH*DATA_WIDTH  channel k word at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port i_output_last  in  1  core has emitted the last output word of the current frame.
REQ-011 SHALL have port o_grant  out  NUM_CH  one-hot grant to the serviced channel; zero when none.
REQ-012 SHALL have port o_start  out  1  one-cycle pulse marking the start of a granted frame.
REQ-013 SHALL have port o_enb  out  1  muxed data-valid to the core.
REQ-014 SHALL have port o_data  out  DATA_WIDTH  muxed data to the core.
REQ-015 SHALL have port o_ch_id  out  $clog2(NUM_CH)  index of the granted channel.
REQ-016 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port o_timeout  out  1  one-cycle pulse when a grant is abandoned.

Function
REQ-018 SHALL implement states IDLE, GRANT, XFER, WAIT_DONE.
REQ-019 IDLE: if i_req nonzero, SHALL select the first requesting channel searching upward (wrapping) from last_ptr+1, register it in o_ch_id/o_grant, and go to GRANT next cycle; otherwise stay in IDLE.
REQ-020 GRANT: o_start SHALL be 1 for exactly this cycle; the word counter and timeout counter SHALL clear; next state XFER.
REQ-021 XFER: o_enb SHALL equal i_enb[o_ch_id] combinationally and o_data SHALL equal the granted channel's slice; i_enb of non-granted channels SHALL be ignored.
REQ-022 XFER: each granted o_enb SHALL increment the word counter; the o_enb that makes the count equal FRAME_WORDS SHALL move the FSM to WAIT_DONE.
REQ-023 Outside XFER, o_enb SHALL be 0 and o_data SHALL be 0; any i_enb there SHALL be dropped.
REQ-024 WAIT_DONE: i_output_last SHALL set last_ptr to o_ch_id, clear o_grant and return to IDLE next cycle; i_output_last in any other state SHALL be ignored.
REQ-025 Timeout counter SHALL increment each XFER/WAIT_DONE cycle without a granted o_enb or i_output_last and clear on either; on reaching TIMEOUT_CYCLES, o_timeout SHALL pulse 1 cycle, last_ptr SHALL update to o_ch_id, o_grant SHALL clear and the FSM SHALL go to IDLE.
REQ-026 Grant SHALL be held for the whole frame regardless of i_req changes; deassertion of the granted i_req mid-frame SHALL NOT end the grant.
REQ-027 Arbitration SHALL be round-robin: a channel that is continuously requesting SHALL be granted within NUM_CH frames.
REQ-028 Word and timeout counters SHALL be sized to hold FRAME_WORDS and TIMEOUT_CYCLES without wrap.

Reset
REQ-029 On i_rst, FSM SHALL enter IDLE and last_ptr SHALL be NUM_CH-1 so channel 0 wins first.
REQ-030 During and after reset: o_grant=0, o_start=0, o_enb=0, o_data=0, o_ch_id=0, o_busy=0, o_timeout=0, counters 0.
REQ-031 Reset asserted mid-frame SHALL abort the grant in the next cycle with no o_timeout pulse.

Verification
REQ-032 Single request: i_req=0001, 243 i_enb on ch0, then i_output_last -> o_start 1 cycle after grant, 243 o_enb, IDLE 1 cycle after i_output_last.
REQ-033 Round-robin: i_req=1111 held for 5 frames -> grant order ch0, ch1, ch2, ch3, ch0.
REQ-034 Isolation: during ch2 grant, toggle i_enb[0] and i_data[0] -> o_enb/o_data follow ch2 only; word count unaffected.
REQ-035 Timeout: grant ch1, supply 10 words then stall 1024 cycles -> o_timeout pulses once, o_grant=0, next grant goes to ch2 if requesting.
REQ-036 Early done: i_output_last during XFER at word 100 -> ignored, FSM stays in XFER until word 243.
REQ-037 Reset mid-frame: i_rst at word 50 of ch3 -> all outputs 0 next cycle, next grant goes to ch0.
